// File: rtl/bitsparse_term_sequencer_if.sv
// Handshake bundle between the weight source, the term sequencer and the
// downstream shift-add PE. The slave modport is the sequencer's view; the
// master modport is the view of whatever drives weights and consumes beats.
// Optional signal out_term_idx exists only when BITSEQ_TERM_IDX_EN is defined.
interface bitsparse_term_sequencer_if #(
  parameter int TAG_WIDTH = 4
);
  // Weight input side
  logic                 in_valid;
  logic                 in_ready;
  logic [7:0]           in_data;
  logic [TAG_WIDTH-1:0] in_tag;

  // Term beat output side
  logic                 out_valid;
  logic                 out_ready;
  logic [2:0]           out_shift;
  logic                 out_sign;
  logic                 out_zero;
  logic                 out_last;
  logic [TAG_WIDTH-1:0] out_tag;

`ifdef BITSEQ_TERM_IDX_EN
  logic [2:0]           out_term_idx;

  modport slave (
    input  in_valid, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_shift, out_sign, out_zero, out_last,
           out_tag, out_term_idx
  );

  modport master (
    output in_valid, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_shift, out_sign, out_zero, out_last,
           out_tag, out_term_idx
  );
`else
  modport slave (
    input  in_valid, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_shift, out_sign, out_zero, out_last,
           out_tag
  );

  modport master (
    output in_valid, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_shift, out_sign, out_zero, out_last,
           out_tag
  );
`endif
endinterface

// File: rtl/bitsparse_term_sequencer.sv
// Bit-serial weight front end. Takes one 8-bit sign-magnitude weight per
// handshake and emits one term beat per set magnitude bit, LSB first, each
// carrying the shift amount for the downstream shift-add PE. A zero
// magnitude still produces exactly one (zero-flagged) beat.
//
// The lowest set bit of the live residual mask is found by a 7-to-3 priority
// encoder; that bit is cleared once its beat has been consumed. All beat
// outputs come straight from registers; only in_ready looks at out_ready so
// that a new weight can be taken on the last-beat cycle with no bubble.
//
// Optional feature macro: BITSEQ_TERM_IDX_EN adds out_term_idx, the ordinal
// of the current beat within its weight.
module bitsparse_term_sequencer #(
  parameter int TAG_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  bitsparse_term_sequencer_if.slave     bus
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Index of the lowest set bit; 0 for an empty mask so the output never floats.
  function automatic logic [2:0] f_lsb_index(input logic [6:0] mask);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (mask[i]) idx = i[2:0];
    end
    return idx;
  endfunction

  // Residual mask with its lowest set bit removed.
  function automatic logic [6:0] f_clear_lsb(input logic [6:0] mask);
    return mask & (mask - 7'd1);
  endfunction

  state_t               r_state;
  logic [6:0]           r_mask;
  logic                 r_sign;
  logic [TAG_WIDTH-1:0] r_tag;

  state_t               w_state_nxt;
  logic [6:0]           w_mask_nxt;
  logic                 w_sign_nxt;
  logic [TAG_WIDTH-1:0] w_tag_nxt;

  logic                 w_busy;
  logic                 w_mask_empty;
  logic                 w_out_zero;
  logic                 w_out_last;
  logic                 w_out_fire;
  logic                 w_in_ready;
  logic                 w_in_fire;

  // Handshake qualifiers derived from registered state and the live strobes.
  always_comb begin
    w_busy       = (r_state == BUSY);
    w_mask_empty = (r_mask == 7'd0);
    w_out_zero   = w_busy && w_mask_empty;
    // Zero or one bit left means this beat finishes the weight.
    w_out_last   = w_busy && (f_clear_lsb(r_mask) == 7'd0);
    w_out_fire   = w_busy && bus.out_ready;
    w_in_ready   = !flush && (!w_busy || (w_out_fire && w_out_last));
    w_in_fire    = bus.in_valid && w_in_ready;
  end

  // State register: busy flag, residual mask, sign and tag of the live weight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_mask  <= 7'd0;
      r_sign  <= 1'b0;
      r_tag   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mask  <= w_mask_nxt;
      r_sign  <= w_sign_nxt;
      r_tag   <= w_tag_nxt;
    end
  end

  // Next-state logic; flush beats a new weight, which beats a finishing or
  // advancing beat. With no beat accepted everything simply holds.
  always_comb begin
    w_state_nxt = r_state;
    w_mask_nxt  = r_mask;
    w_sign_nxt  = r_sign;
    w_tag_nxt   = r_tag;
    if (flush) begin
      w_state_nxt = IDLE;
      w_mask_nxt  = 7'd0;
    end else if (w_in_fire) begin
      w_state_nxt = BUSY;
      w_mask_nxt  = bus.in_data[6:0];
      w_sign_nxt  = bus.in_data[7];
      w_tag_nxt   = bus.in_tag;
    end else if (w_out_fire && w_out_last) begin
      w_state_nxt = IDLE;
      w_mask_nxt  = 7'd0;
    end else if (w_out_fire) begin
      w_mask_nxt  = f_clear_lsb(r_mask);
    end
  end

  // Output logic; beat fields depend only on registers. Negative zero is
  // reported with a positive sign so the PE never sees a signed empty term.
  always_comb begin
    bus.in_ready  = w_in_ready;
    bus.out_valid = w_busy;
    bus.out_shift = w_mask_empty ? 3'd0 : f_lsb_index(r_mask);
    bus.out_zero  = w_out_zero;
    bus.out_last  = w_out_last;
    bus.out_sign  = r_sign && !w_out_zero;
    bus.out_tag   = r_tag;
  end

`ifdef BITSEQ_TERM_IDX_EN
  logic [2:0] r_term_idx;
  logic [2:0] w_term_idx_nxt;

  // Beat ordinal: restarts with every new, flushed or completed weight.
  always_comb begin
    w_term_idx_nxt = r_term_idx;
    if (flush || w_in_fire || (w_out_fire && w_out_last)) begin
      w_term_idx_nxt = 3'd0;
    end else if (w_out_fire) begin
      w_term_idx_nxt = r_term_idx + 3'd1;
    end
  end

  // Beat ordinal register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_term_idx <= 3'd0;
    end else begin
      r_term_idx <= w_term_idx_nxt;
    end
  end

  // Beat ordinal output.
  always_comb begin
    bus.out_term_idx = r_term_idx;
  end
`else
  // Without the ordinal feature the beat carries no position information.
`endif

endmodule
